// File: rtl/mdu_ctrl_pkg.sv
// Shared opcode encodings, FSM states and opcode-class helpers for the MD unit.
// MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU multiply-accumulate ops.
package mdu_ctrl_pkg;

   localparam int MDU_OP_W = 4;

   typedef enum logic [MDU_OP_W-1:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   function automatic logic is_mul_op(input logic [MDU_OP_W-1:0] op);
      logic hit;
      hit = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
      hit = hit || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
      return hit;
   endfunction

   function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational multiply/divide datapath: op, rs, rt and current {HI,LO} -> 64-bit {HI,LO}.
// MDU_MADD_EN adds accumulate/subtract variants that fold the product into {HI,LO}.
module mdu_ctrl_arith
   import mdu_ctrl_pkg::*;
(
   input  logic [MDU_OP_W-1:0] op,
   input  logic [31:0]         rs,
   input  logic [31:0]         rt,
   input  logic [63:0]         hilo,
   output logic [63:0]         result
);

   logic signed [63:0] rs_s;
   logic signed [63:0] rt_s;
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               sgn;
   logic               neg_a;
   logic               neg_b;
   logic        [31:0] mag_a;
   logic        [31:0] mag_b;
   logic        [31:0] divisor;
   logic        [31:0] q_mag;
   logic        [31:0] r_mag;
   logic        [31:0] quot;
   logic        [31:0] rem;

   assign rs_s   = {{32{rs[31]}}, rs};
   assign rt_s   = {{32{rt[31]}}, rt};
   assign prod_s = rs_s * rt_s;
   assign prod_u = {32'd0, rs} * {32'd0, rt};

   // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
   assign sgn     = (op == OP_DIV);
   assign neg_a   = sgn & rs[31];
   assign neg_b   = sgn & rt[31];
   assign mag_a   = neg_a ? (32'd0 - rs) : rs;
   assign mag_b   = neg_b ? (32'd0 - rt) : rt;
   assign divisor = (rt == 32'd0) ? 32'd1 : mag_b;
   assign q_mag   = mag_a / divisor;
   assign r_mag   = mag_a % divisor;
   assign quot    = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
   assign rem     = neg_a ? (32'd0 - r_mag) : r_mag;

   always_comb begin
      result = hilo;
      case (op)
         OP_MULT:  result = prod_s;
         OP_MULTU: result = prod_u;
         OP_DIV,
         OP_DIVU:  result = (rt == 32'd0) ? hilo : {rem, quot};
`ifdef MDU_MADD_EN
         OP_MADD:  result = hilo + prod_s;
         OP_MADDU: result = hilo + prod_u;
         OP_MSUB:  result = hilo - prod_s;
         OP_MSUBU: result = hilo - prod_u;
`endif
         default:  result = hilo;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV sequencer beside the E-stage ALU: owns HI/LO, busy and the D-stage stall.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU as multiply-latency ops.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic                clk,
   input  logic                reset,
   input  logic [MDU_OP_W-1:0] op_i,
   input  logic                op_valid_i,
   input  logic [31:0]         rs_i,
   input  logic [31:0]         rt_i,
   input  logic                d_md_use_i,
   output logic                start_o,
   output logic                busy_o,
   output logic                stall_o,
   output logic [31:0]         hi_o,
   output logic [31:0]         lo_o
);

   localparam int CNT_W = $clog2(DIV_CYCLES + 1);

   mdu_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [63:0]      pend;
   logic [63:0]      result;
   logic             idle;
   logic             is_mul;
   logic             is_div;
   logic             mthi_acc;
   logic             mtlo_acc;

   mdu_ctrl_arith u_arith (
      .op     (op_i),
      .rs     (rs_i),
      .rt     (rt_i),
      .hilo   ({hi_o, lo_o}),
      .result (result)
   );

   assign idle     = (state == ST_IDLE);
   assign is_mul   = is_mul_op(op_i);
   assign is_div   = is_div_op(op_i);
   assign start_o  = op_valid_i & (is_mul | is_div) & idle;
   assign mthi_acc = op_valid_i & idle & ~start_o & (op_i == OP_MTHI);
   assign mtlo_acc = op_valid_i & idle & ~start_o & (op_i == OP_MTLO);
   assign stall_o  = d_md_use_i & (start_o | busy_o);

   // Result is captured at accept; HI/LO only change when the countdown expires.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         busy_o <= 1'b0;
         pend   <= 64'd0;
         hi_o   <= 32'd0;
         lo_o   <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_o) begin
                  pend   <= result;
                  cnt    <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  busy_o <= 1'b1;
                  state  <= ST_RUN;
               end else begin
                  if (mthi_acc) hi_o <= rs_i;
                  if (mtlo_acc) lo_o <= rs_i;
               end
            end
            ST_RUN: begin
               if (cnt == CNT_W'(1)) begin
                  {hi_o, lo_o} <= pend;
                  cnt          <= '0;
                  busy_o       <= 1'b0;
                  state        <= ST_IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state  <= ST_IDLE;
               cnt    <= '0;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus randomized ops against a reference model.
// Build with MDU_MADD_EN to cover the multiply-accumulate ops.
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  op_i;
   logic        op_valid_i;
   logic [31:0] rs_i;
   logic [31:0] rt_i;
   logic        d_md_use_i;
   logic        start_o;
   logic        busy_o;
   logic        stall_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int          vectors = 0;
   int          miscompares = 0;
   logic [63:0] m_hl;

   always #5 clk = ~clk;

   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk        (clk),
      .reset      (reset),
      .op_i       (op_i),
      .op_valid_i (op_valid_i),
      .rs_i       (rs_i),
      .rt_i       (rt_i),
      .d_md_use_i (d_md_use_i),
      .start_o    (start_o),
      .busy_o     (busy_o),
      .stall_o    (stall_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Busy length of an accepted op; 0 means it is not a multiply/divide.
   function automatic int ref_lat(input logic [3:0] op);
      case (op)
         OP_MULT, OP_MULTU: return MC;
         OP_DIV, OP_DIVU:   return DC;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return MC;
`endif
         default: return 0;
      endcase
   endfunction

   function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] uq;
      logic [63:0] ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         OP_MULT:  return sa * sb;
         OP_MULTU: return ua * ub;
         OP_DIV: begin
            if (b == 32'd0) return hl;
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         OP_DIVU: begin
            if (b == 32'd0) return hl;
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
         OP_MTHI: return {a, hl[31:0]};
         OP_MTLO: return {hl[63:32], a};
`ifdef MDU_MADD_EN
         OP_MADD:  return hl + (sa * sb);
         OP_MADDU: return hl + (ua * ub);
         OP_MSUB:  return hl - (sa * sb);
         OP_MSUBU: return hl - (ua * ub);
`endif
         default: return hl;
      endcase
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 9))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Presents one op for a cycle, walks the busy window, then checks the committed HI/LO.
   // inject > 0 drives a random op on every busy cycle, which must be ignored.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic mduse, input bit inject, input string tag);
      int          n;
      logic [63:0] exp_new;
      logic [63:0] hl_obs;
      n       = ref_lat(op);
      exp_new = ref_op(op, a, b, m_hl);
      op_i = op; op_valid_i = 1'b1; rs_i = a; rt_i = b; d_md_use_i = mduse;
      #1;
      chk({tag, ":start"}, {63'd0, start_o}, {63'd0, (n > 0)});
      chk({tag, ":stall_t"}, {63'd0, stall_o}, {63'd0, mduse & (n > 0)});
      @(posedge clk); #1;
      op_valid_i = 1'b0; op_i = OP_NONE; rs_i = $urandom; rt_i = $urandom;
      for (int i = 1; i <= n; i++) begin
         if (inject) begin
            op_valid_i = 1'b1;
            op_i       = 4'($urandom_range(0, 10));
            rs_i       = $urandom;
            rt_i       = $urandom;
         end
         #1;
         chk({tag, ":busy"}, {63'd0, busy_o}, 64'd1);
         chk({tag, ":stall_run"}, {63'd0, stall_o}, {63'd0, mduse});
         if (inject) chk({tag, ":no_start_run"}, {63'd0, start_o}, 64'd0);
         hl_obs = {hi_o, lo_o};
         if (i == n) chk({tag, ":hilo_hold"}, hl_obs, m_hl);
         @(posedge clk); #1;
      end
      op_valid_i = 1'b0; op_i = OP_NONE;
      #1;
      hl_obs = {hi_o, lo_o};
      chk({tag, ":busy_done"}, {63'd0, busy_o}, 64'd0);
      chk({tag, ":stall_done"}, {63'd0, stall_o}, 64'd0);
      chk({tag, ":hilo"}, hl_obs, exp_new);
      m_hl = exp_new;
      d_md_use_i = 1'b0;
   endtask

   initial begin
      logic [63:0] hl_obs;
      logic [3:0]  rop;
      reset = 1'b1; op_i = OP_NONE; op_valid_i = 1'b0; rs_i = '0; rt_i = '0; d_md_use_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      m_hl = 64'd0;

      // Idle after reset, even with an MD op sitting in D.
      d_md_use_i = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("rst:busy", {63'd0, busy_o}, 64'd0);
      chk("rst:stall", {63'd0, stall_o}, 64'd0);
      chk("rst:hi", {32'd0, hi_o}, 64'd0);
      chk("rst:lo", {32'd0, lo_o}, 64'd0);
      d_md_use_i = 1'b0;

      run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, "mult");
      chk("mult:const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
      run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, "multu");
      chk("multu:const", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div");
      chk("div:const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(OP_DIVU, 32'd100, 32'd0, 1'b1, 1'b0, "divu0");
      chk("divu0:const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "divovf");
      chk("divovf:const", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
      run_op(OP_MTHI, 32'h0000_1234, 32'd0, 1'b0, 1'b0, "mthi");
      chk("mthi:const", {32'd0, hi_o}, 64'h1234);
      run_op(OP_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0, "mtlo");
      run_op(OP_MULT, 32'd7, 32'd9, 1'b1, 1'b1, "mult_inj");
      run_op(OP_NONE, 32'hDEAD_BEEF, 32'd5, 1'b1, 1'b0, "none");

      // Reset three cycles into a divide: op aborted, result discarded.
      run_op(OP_MTHI, 32'h5555_0000, 32'd0, 1'b0, 1'b0, "pre_rst");
      op_i = OP_DIV; op_valid_i = 1'b1; rs_i = 32'd1000; rt_i = 32'd7;
      @(posedge clk); #1;
      op_valid_i = 1'b0; op_i = OP_NONE;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_hl = 64'd0;
      hl_obs = {hi_o, lo_o};
      chk("abort:busy", {63'd0, busy_o}, 64'd0);
      chk("abort:hilo", hl_obs, 64'd0);
      repeat (DC) @(posedge clk);
      #1;
      hl_obs = {hi_o, lo_o};
      chk("abort:hilo_late", hl_obs, 64'd0);
      chk("abort:busy_late", {63'd0, busy_o}, 64'd0);

`ifdef MDU_MADD_EN
      run_op(OP_MTHI, 32'd0, 32'd0, 1'b0, 1'b0, "madd_hi");
      run_op(OP_MTLO, 32'd5, 32'd0, 1'b0, 1'b0, "madd_lo");
      run_op(OP_MADD, 32'd2, 32'd3, 1'b1, 1'b0, "madd");
      chk("madd:const", {hi_o, lo_o}, 64'h0000_0000_0000_000B);
      run_op(OP_MSUB, 32'd4, 32'd4, 1'b0, 1'b0, "msub");
      chk("msub:const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFB);
`else
      run_op(OP_MTLO, 32'd5, 32'd0, 1'b0, 1'b0, "madd_lo");
      run_op(OP_MADD, 32'd2, 32'd3, 1'b1, 1'b0, "madd_off");
      chk("madd_off:const", {hi_o, lo_o}, 64'h0000_0000_0000_0005);
`endif

      for (int k = 0; k < 40; k++) begin
`ifdef MDU_MADD_EN
         rop = 4'($urandom_range(0, 10));
`else
         rop = 4'($urandom_range(0, 6));
`endif
         run_op(rop, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
